// File: rtl/sound_dac_multi.sv
// Multi-channel sigma-delta audio DAC: per-channel ready/valid double buffer feeding a 1-bit modulator.
// Define SOUND_DAC_ORDER2_EN to build second-order modulators instead of the default first-order ones.
module sound_dac_multi #(
   parameter int CHANNELS = 2,
   parameter int WIDTH    = 16,
   parameter int CLK_DIV  = 5
) (
   input  logic                         CLK_BASE,
   input  logic                         RESET_n,
   input  logic [CHANNELS*WIDTH-1:0]    IN_DATA,
   input  logic [CHANNELS-1:0]          IN_VALID,
   output logic [CHANNELS-1:0]          IN_READY,
   input  logic                         MUTE,
   output logic                         DAC_TICK,
   output logic [CHANNELS-1:0]          OUT
);

   localparam int            CW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] DIV_MAX = CW'(CLK_DIV - 1);

   logic [CW-1:0] div_q;
   logic [CW-1:0] div_d;

   always_comb begin
      div_d = div_q - 1'b1;
      if (div_q == '0) div_d = DIV_MAX;
   end

   always_ff @(posedge CLK_BASE or negedge RESET_n) begin
      if (!RESET_n) div_q <= DIV_MAX;
      else          div_q <= div_d;
   end

   // The reset value is never zero (CLK_DIV >= 2), so DAC_TICK is low throughout reset.
   assign DAC_TICK = (div_q == '0);

`ifdef SOUND_DAC_ORDER2_EN
   localparam int                   EW      = WIDTH + 4;
   localparam logic signed [EW:0]   SAT_HI  = (EW+1)'((1 << (WIDTH + 2)) - 1);
   localparam logic signed [EW:0]   SAT_LO  = -SAT_HI;
   localparam logic signed [EW:0]   FB_MAG  = (EW+1)'(1 << (WIDTH - 1));

   function automatic logic signed [EW-1:0] sat_e(input logic signed [EW:0] v);
      logic signed [EW:0] r;
      r = v;
      if (v > SAT_HI) r = SAT_HI;
      if (v < SAT_LO) r = SAT_LO;
      return $signed(r[EW-1:0]);
   endfunction
`else
   localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};
`endif

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic signed [WIDTH-1:0] stage_q;
      logic signed [WIDTH-1:0] active_q;
      logic                    full_q;
      logic                    out_q;
      logic                    accept;
      logic signed [WIDTH-1:0] x;

      assign accept = IN_VALID[c] && !full_q;

      // Accept and transfer are exclusive: accept requires full_q == 0, transfer requires full_q == 1.
      always_ff @(posedge CLK_BASE or negedge RESET_n) begin
         if (!RESET_n) begin
            stage_q  <= '0;
            active_q <= '0;
            full_q   <= 1'b0;
         end else if (accept) begin
            stage_q  <= $signed(IN_DATA[c*WIDTH +: WIDTH]);
            full_q   <= 1'b1;
         end else if (DAC_TICK && full_q) begin
            active_q <= stage_q;
            full_q   <= 1'b0;
         end
      end

      assign x = MUTE ? '0 : active_q;

`ifdef SOUND_DAC_ORDER2_EN
      logic signed [EW-1:0] e1_q;
      logic signed [EW-1:0] e2_q;
      logic signed [EW-1:0] e1_d;
      logic signed [EW-1:0] e2_d;
      logic signed [EW:0]   fb;
      logic signed [EW:0]   s1;
      logic signed [EW:0]   s2;

      always_comb begin
         fb   = out_q ? FB_MAG : -FB_MAG;
         s1   = $signed({e1_q[EW-1], e1_q}) + $signed({{(EW+1-WIDTH){x[WIDTH-1]}}, x}) - fb;
         e1_d = sat_e(s1);
         s2   = $signed({e2_q[EW-1], e2_q}) + $signed({e1_d[EW-1], e1_d}) - fb;
         e2_d = sat_e(s2);
      end

      always_ff @(posedge CLK_BASE or negedge RESET_n) begin
         if (!RESET_n) begin
            e1_q  <= '0;
            e2_q  <= '0;
            out_q <= 1'b0;
         end else if (DAC_TICK) begin
            e1_q  <= e1_d;
            e2_q  <= e2_d;
            out_q <= ~e2_d[EW-1];
         end
      end
`else
      logic [WIDTH-1:0] acc_q;
      logic [WIDTH:0]   acc_d;
      logic [WIDTH-1:0] u;

      // Offset-binary input; the carry out of the accumulator is the output bit.
      always_comb begin
         u     = x ^ MSB_MASK;
         acc_d = {1'b0, acc_q} + {1'b0, u};
      end

      always_ff @(posedge CLK_BASE or negedge RESET_n) begin
         if (!RESET_n) begin
            acc_q <= '0;
            out_q <= 1'b0;
         end else if (DAC_TICK) begin
            acc_q <= acc_d[WIDTH-1:0];
            out_q <= acc_d[WIDTH];
         end
      end
`endif

      assign IN_READY[c] = ~full_q;
      assign OUT[c]      = out_q;
   end

endmodule

// File: tb/tb_sound_dac_multi.sv
// Directed self-checking bench for sound_dac_multi (CHANNELS=2, WIDTH=16, CLK_DIV=5).
module tb_sound_dac_multi;
   localparam int CH  = 2;
   localparam int W   = 16;
   localparam int DIV = 5;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [CH*W-1:0]   in_data = '0;
   logic [CH-1:0]     in_valid = '0;
   logic [CH-1:0]     in_ready;
   logic              mute = 1'b0;
   logic              tick;
   logic [CH-1:0]     out;

   int n_run  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   sound_dac_multi #(.CHANNELS(CH), .WIDTH(W), .CLK_DIV(DIV)) dut (
      .CLK_BASE (clk),
      .RESET_n  (rst_n),
      .IN_DATA  (in_data),
      .IN_VALID (in_valid),
      .IN_READY (in_ready),
      .MUTE     (mute),
      .DAC_TICK (tick),
      .OUT      (out)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      in_valid = '0;
      mute     = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Waits for a tick cycle, then returns OUT sampled after the tick edge.
   task automatic next_tick(output logic [CH-1:0] o);
      int guard = 0;
      while (!tick && guard < 4*DIV) begin
         @(negedge clk);
         guard++;
      end
      if (!tick) check_eq("tick_timeout", 32'(tick), 32'd1);
      @(negedge clk);
      o = out;
   endtask

   task automatic load0(input logic [W-1:0] v);
      in_data[W-1:0] = v;
      in_valid[0]    = 1'b1;
      @(negedge clk);
      in_valid[0]    = 1'b0;
   endtask

   task automatic count_ones(input int n, output int c0, output int c1);
      logic [CH-1:0] o;
      c0 = 0;
      c1 = 0;
      for (int i = 0; i < n; i++) begin
         next_tick(o);
         c0 += int'(o[0]);
         c1 += int'(o[1]);
      end
   endtask

   initial begin
      #1ms;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      logic [CH-1:0] o;
      int c0, c1;

      // Reset state, with inputs driven to show they are ignored
      repeat (2) @(negedge clk);
      in_valid = 2'b11;
      @(negedge clk);
      check_eq("rst_out", 32'(out), 32'h0);
      check_eq("rst_ready", 32'(in_ready), 32'h3);
      check_eq("rst_tick", 32'(tick), 32'h0);
      in_valid = '0;
      rst_n    = 1'b1;
      for (int k = 1; k <= 2*DIV; k++) begin
         check_eq($sformatf("tick_before_edge%0d", k), 32'(tick), 32'((k % DIV) == 0));
         @(negedge clk);
      end

`ifdef SOUND_DAC_ORDER2_EN
      do_reset();
      next_tick(o);
      load0(16'h4000);
      next_tick(o);
      count_ones(32, c0, c1);
      count_ones(1024, c0, c1);
      check_eq("o2_density_0x4000", 32'(c0 >= 767 && c0 <= 769), 32'd1);
      check_eq("o2_ready_idle", 32'(in_ready), 32'h3);
`else
      // Midscale with nothing loaded
      do_reset();
      c0 = 0;
      c1 = 0;
      for (int i = 0; i < 64; i++) begin
         next_tick(o);
         if (i < 4) check_eq($sformatf("mid_pat%0d", i), 32'(o[0]), 32'(i % 2));
         c0 += int'(o[0]);
         c1 += int'(o[1]);
      end
      check_eq("mid_ones_ch0", 32'(c0), 32'd32);
      check_eq("mid_ones_ch1", 32'(c1), 32'd32);

      // Full scale: transfer on tick 2 leaves the accumulator at 0
      do_reset();
      next_tick(o);
      load0(16'h7FFF);
      next_tick(o);
      check_eq("fs_xfer_tick", 32'(o[0]), 32'd1);
      count_ones(256, c0, c1);
      check_eq("fs_ones_256", 32'(c0), 32'd255);

      // Mute from accumulator 0xFF00 gives 1,0,1,0...
      mute = 1'b1;
      for (int i = 0; i < 8; i++) begin
         next_tick(o);
         check_eq($sformatf("mute_pat%0d", i), 32'(o[0]), 32'((i % 2) == 0));
      end
      check_eq("mute_ready", 32'(in_ready), 32'h3);
      mute = 1'b0;
      count_ones(16, c0, c1);
      check_eq("unmute_ones_16", 32'(c0), 32'd16);

      // Reset while a sample is staged
      check_eq("pre_rst_out0", 32'(out[0]), 32'd1);
      load0(16'h1234);
      check_eq("staged_ready", 32'(in_ready), 32'h2);
      rst_n = 1'b0;
      #1;
      check_eq("midrst_out", 32'(out), 32'h0);
      check_eq("midrst_ready", 32'(in_ready), 32'h3);
      check_eq("midrst_tick", 32'(tick), 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      count_ones(64, c0, c1);
      check_eq("postrst_ones_ch0", 32'(c0), 32'd32);
      check_eq("postrst_ones_ch1", 32'(c1), 32'd32);

      // Back-to-back handshake on ch0
      in_data[W-1:0] = 16'h1234;
      in_valid[0]    = 1'b1;
      @(negedge clk);
      check_eq("hs_accept1", 32'(in_ready), 32'h2);
      in_data[W-1:0] = 16'h5678;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         check_eq($sformatf("hs_hold%0d", k), 32'(in_ready), 32'h2);
      end
      check_eq("hs_xfer_tick", 32'(tick), 32'd1);
      @(negedge clk);
      check_eq("hs_after_xfer", 32'(in_ready), 32'h3);
      @(negedge clk);
      check_eq("hs_accept2", 32'(in_ready), 32'h2);
      in_valid[0] = 1'b0;

      // Negative full scale staged and transferred while muted
      do_reset();
      next_tick(o);
      mute = 1'b1;
      load0(16'h8000);
      check_eq("neg_staged_ready", 32'(in_ready), 32'h2);
      next_tick(o);
      mute = 1'b0;
      count_ones(32, c0, c1);
      check_eq("neg_ones_ch0", 32'(c0), 32'd0);
      check_eq("neg_ones_ch1", 32'(c1), 32'd16);
`endif

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/sound_dac_multi.md
# sound_dac_multi

Multi-channel sigma-delta audio DAC for the cartridge board: replaces the fixed 21.6 MHz enable divider plus per-output single-channel 1-bit DACs with one parametrised block. Sits between MAIN's sound interfaces and the SOUND_INT/SOUND_EXT pins. Each channel accepts signed PCM through a ready/valid handshake into a double buffer and drives one 1-bit pin. The shared modulator rate is derived internally from CLK_BASE.

## Interface
- CHANNELS, 2, number of independent channels/output pins (1..8)
- WIDTH, 16, sample width, signed two's complement (8..24)
- CLK_DIV, 5, modulator tick period in CLK_BASE cycles (2..256); 108 MHz / 5 = 21.6 MHz
- CLK_BASE  input  1  system clock, 108 MHz
- RESET_n  input  1  asynchronous, active-low reset
- IN_DATA  input  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
- IN_VALID  input  CHANNELS  per-channel sample valid
- IN_READY  output  CHANNELS  per-channel staging slot empty
- MUTE  input  1  force all channels to midscale
- DAC_TICK  output  1  one-cycle pulse per modulator step
- OUT  output  CHANNELS  1-bit modulated outputs, registered

## Operation
- Divider: counter reset to CLK_DIV-1; decrements each cycle; on 0 reloads CLK_DIV-1. DAC_TICK = (counter == 0), combinational from the counter.
- Per-channel double buffer: staging register, full flag, active register.
  - IN_READY[c] = !full[c].
  - The accept condition is IN_VALID[c] && IN_READY[c]. On accept, staging <= slice and full <= 1.
  - On DAC_TICK with full=1: active <= staging and full <= 0. Since IN_READY is 0 while full, accept and transfer cannot occur in the same cycle.
  - On an accept during a tick cycle with full=0: the sample lands in staging and transfers on the next tick.
  - With no new sample, active holds its value (sample-and-hold).
- Modulator input: x = MUTE ? 0 : active (signed).
- First-order modulator (default):
  - u = x with MSB inverted (offset binary).
  - Accumulator is WIDTH+1 bits. On tick: acc <= {1'b0, acc[WIDTH-1:0]} + u.
  - OUT[c] <= acc_next[WIDTH] (the carry).
- Arithmetic: no saturation is needed in first order; wrap-around of acc[WIDTH-1:0] is the intended behaviour.

## Timing
- Reset values: divider = CLK_DIV-1; staging = 0; active = 0; full = 0; accumulators/integrators = 0; OUT = 0.
- While RESET_n is low: IN_READY reads 1 and DAC_TICK reads 0; inputs are ignored.
- After RESET_n rises, the first DAC_TICK occurs on the CLK_DIV-th rising edge of CLK_BASE.
- Latencies:
  - IN_READY drops the cycle after an accept.
  - The sample becomes active at the first tick after the accept, i.e. 1..CLK_DIV cycles later.
  - OUT reflects the new active value from the following tick.
- OUT changes only on the cycle after a DAC_TICK.
- MUTE is sampled on tick cycles only. It does not affect the handshake or the buffers.
- Asserting reset mid-operation clears state immediately (asynchronous reset). A pending staged sample is discarded.

## Configuration
- SOUND_DAC_ORDER2_EN defined: each channel uses a second-order modulator instead of the first-order one.
  - State: two signed integrators e1 and e2, each WIDTH+4 bits.
  - Feedback: fb = OUT[c] ? +2^(WIDTH-1) : -2^(WIDTH-1).
  - On tick: e1 <= sat(e1 + x - fb); e2 <= sat(e2 + e1_next - fb); OUT[c] <= (e2_next >= 0).
  - sat clamps to ±(2^(WIDTH+2)-1).
  - Reset value of OUT stays 0. The handshake and MUTE behave identically to the first-order mode.
- SOUND_DAC_ORDER2_EN undefined: the first-order accumulator only; no integrator logic is present.

## Test plan
- Reset release (CHANNELS=2, WIDTH=16, CLK_DIV=5): OUT=00 and IN_READY=11 while in reset; the first DAC_TICK is on edge 5 after release, then every 5 cycles.
- Midscale: no samples loaded, first order -> OUT[0] toggles 0,1,0,1 on successive ticks; exactly 32 ones in 64 ticks.
- Full scale: load 0x7FFF on ch0 -> 255 ones in the 256 ticks after activation. Load 0x8000 -> OUT[0]=0 on every tick.
- Handshake: IN_VALID[0] held high with 0x1234 then 0x5678 on back-to-back cycles. Required: 0x1234 accepted and IN_READY[0]=0 the next cycle; 0x5678 accepted only after the transfer tick; ch1 IN_READY is unaffected throughout.
- MUTE: with 0x7FFF active, assert MUTE -> the alternating 0/1 midscale pattern appears from the next tick; deassert -> full-scale density returns; the staged sample is preserved.
- Reset mid-stream: assert RESET_n low while full[0]=1 -> OUT=0 and IN_READY=1 immediately. After release, active=0, giving the midscale pattern. With SOUND_DAC_ORDER2_EN, a constant 0x4000 gives a ones density of 0.75±1/1024 over 1024 ticks.
